// File: rtl/vmem_seq.sv
// Multi-beat vector load/store sequencer: moves one LANES-wide vector over a LANE_W memory port.
// Optional VMEM_TIMEOUT_EN adds a per-beat wait timeout with a sticky o_err flag.
module vmem_seq #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic                      i_is_store,
    input  logic [ADDR_W-1:0]         i_base_addr,
    input  logic [LANES*LANE_W-1:0]   i_vdata_in,
    output logic                      o_mem_req,
    output logic                      o_mem_we,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [LANE_W-1:0]         o_mem_wdata,
    input  logic                      i_mem_ack,
    input  logic [LANE_W-1:0]         i_mem_rdata,
    output logic                      o_stall,
    output logic [LANES*LANE_W-1:0]   o_vdata_out,
    output logic                      o_vreg_we,
    output logic                      o_done,
    output logic                      o_err
);

    localparam int unsigned KW = $clog2(LANES);

    typedef enum logic [1:0] {StIdle, StBeat, StFin} state_e;

    state_e                    r_state;
    state_e                    w_state_d;
    logic [KW-1:0]             r_k;
    logic                      r_is_store;
    logic [ADDR_W-1:0]         r_base;
    logic [LANES*LANE_W-1:0]   r_vdata;
    logic [LANES*LANE_W-1:0]   r_vout;
    logic                      w_last;
    logic                      w_timeout;
    logic                      w_timed_out;

    assign w_last = (r_k == KW'(LANES - 1));

`ifdef VMEM_TIMEOUT_EN
    logic [15:0] r_wait;
    logic        r_err;
    logic        r_to;

    // Fires on the 65535th consecutive BEAT cycle without an ack.
    assign w_timeout   = (r_state == StBeat) && !i_mem_ack && (r_wait == 16'hFFFE);
    assign w_timed_out = r_to;
    assign o_err       = r_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wait <= '0;
            r_err  <= 1'b0;
            r_to   <= 1'b0;
        end else if (r_state == StIdle) begin
            r_wait <= '0;
            if (i_start) begin
                r_to <= 1'b0;
            end
        end else if (r_state == StBeat) begin
            r_wait <= i_mem_ack ? 16'h0000 : r_wait + 16'h0001;
            if (w_timeout) begin
                r_err <= 1'b1;
                r_to  <= 1'b1;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign w_timed_out = 1'b0;
    assign o_err       = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= StIdle;
            r_k        <= '0;
            r_is_store <= 1'b0;
            r_base     <= '0;
            r_vdata    <= '0;
            r_vout     <= '0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StIdle && i_start) begin
                r_is_store <= i_is_store;
                r_base     <= i_base_addr;
                r_vdata    <= i_vdata_in;
                r_k        <= '0;
            end else if (r_state == StBeat && i_mem_ack) begin
                if (!r_is_store) begin
                    r_vout[int'(r_k)*LANE_W +: LANE_W] <= i_mem_rdata;
                end
                if (!w_last) begin
                    r_k <= r_k + KW'(1);
                end
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        o_mem_req = 1'b0;
        o_mem_we  = 1'b0;
        o_stall   = 1'b0;
        o_done    = 1'b0;
        o_vreg_we = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    o_stall   = 1'b1;
                    w_state_d = StBeat;
                end
            end
            StBeat: begin
                o_mem_req = 1'b1;
                o_mem_we  = r_is_store;
                o_stall   = 1'b1;
                if ((i_mem_ack && w_last) || w_timeout) begin
                    w_state_d = StFin;
                end
            end
            StFin: begin
                o_done    = 1'b1;
                o_stall   = 1'b1;
                o_vreg_we = !r_is_store && !w_timed_out;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Address and data are driven only while a beat is requested so idle outputs read 0.
    assign o_mem_addr  = o_mem_req ? r_base + (ADDR_W'(r_k) << 2) : '0;
    assign o_mem_wdata = o_mem_req ? r_vdata[int'(r_k)*LANE_W +: LANE_W] : '0;
    assign o_vdata_out = r_vout;

endmodule

// File: tb/tb_vmem_seq.sv
// Directed self-checking bench for vmem_seq (4 lanes x 32 bits, 32-bit addresses).
module tb_vmem_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_store;
    logic [31:0]  base_addr;
    logic [127:0] vdata_in;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic         stall;
    logic [127:0] vdata_out;
    logic         vreg_we;
    logic         done;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vmem_seq #(
        .LANES  (4),
        .LANE_W (32),
        .ADDR_W (32)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_is_store  (is_store),
        .i_base_addr (base_addr),
        .i_vdata_in  (vdata_in),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata),
        .o_stall     (stall),
        .o_vdata_out (vdata_out),
        .o_vreg_we   (vreg_we),
        .o_done      (done),
        .o_err       (err)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [127:0] v_load1;
        logic [127:0] v_load2;
        logic [31:0]  addrs[4];

        rst = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = '0;
        vdata_in = '0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset held two cycles.
        next_cycle(); next_cycle(); next_cycle();
        rst = 1'b1; settle();
        chk("rst_req", {127'd0, mem_req}, 128'd0);
        chk("rst_we", {127'd0, mem_we}, 128'd0);
        chk("rst_addr", {96'd0, mem_addr}, 128'd0);
        chk("rst_wdata", {96'd0, mem_wdata}, 128'd0);
        chk("rst_stall", {127'd0, stall}, 128'd0);
        chk("rst_vout", vdata_out, 128'd0);
        chk("rst_vreg_we", {127'd0, vreg_we}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_err", {127'd0, err}, 128'd0);

        // Zero-wait load from 0x100.
        next_cycle();
        start = 1'b1; is_store = 1'b0; base_addr = 32'h100; settle();
        chk("ld_start_stall", {127'd0, stall}, 128'd1);
        chk("ld_start_req", {127'd0, mem_req}, 128'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hA0 + k; settle();
            chk($sformatf("ld_req%0d", k), {127'd0, mem_req}, 128'd1);
            chk($sformatf("ld_we%0d", k), {127'd0, mem_we}, 128'd0);
            chk($sformatf("ld_addr%0d", k), {96'd0, mem_addr}, 128'h100 + 128'(4 * k));
        end
        next_cycle(); settle();
        v_load1 = 128'h000000A3_000000A2_000000A1_000000A0;
        chk("ld_done", {127'd0, done}, 128'd1);
        chk("ld_vreg_we", {127'd0, vreg_we}, 128'd1);
        chk("ld_fin_stall", {127'd0, stall}, 128'd1);
        chk("ld_fin_req", {127'd0, mem_req}, 128'd0);
        chk("ld_vout", vdata_out, v_load1);
        next_cycle(); mem_ack = 1'b0; settle();
        chk("ld_idle_stall", {127'd0, stall}, 128'd0);
        chk("ld_idle_done", {127'd0, done}, 128'd0);

        // Store from 0x200, ack on every third beat cycle.
        start = 1'b1; is_store = 1'b1; base_addr = 32'h200;
        vdata_in = 128'h00000044_00000033_00000022_00000011; settle();
        chk("st_start_stall", {127'd0, stall}, 128'd1);
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++) begin
                next_cycle();
                start = 1'b0; vdata_in = '0; base_addr = 32'hDEAD0000;
                mem_ack = (c == 2); mem_rdata = 32'hBAD; settle();
                chk($sformatf("st_we%0d_%0d", k, c), {127'd0, mem_we}, 128'd1);
                chk($sformatf("st_addr%0d_%0d", k, c), {96'd0, mem_addr}, 128'h200 + 128'(4 * k));
                chk($sformatf("st_wdata%0d_%0d", k, c), {96'd0, mem_wdata},
                    128'h11 * 128'(k + 1));
                chk($sformatf("st_stall%0d_%0d", k, c), {127'd0, stall}, 128'd1);
            end
        end
        next_cycle(); mem_ack = 1'b0; settle();
        chk("st_done", {127'd0, done}, 128'd1);
        chk("st_vreg_we", {127'd0, vreg_we}, 128'd0);
        chk("st_fin_stall", {127'd0, stall}, 128'd1);
        chk("st_vout_kept", vdata_out, v_load1);

        // Load at 0xFFFFFFF8 wraps; a start pulse mid-transfer is ignored.
        next_cycle();
        start = 1'b1; is_store = 1'b0; base_addr = 32'hFFFF_FFF8; settle();
        addrs[0] = 32'hFFFF_FFF8; addrs[1] = 32'hFFFF_FFFC; addrs[2] = 32'h0; addrs[3] = 32'h4;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            start = (k == 1); is_store = (k == 1); base_addr = 32'h500;
            mem_ack = 1'b1; mem_rdata = 32'hB0 + k; settle();
            chk($sformatf("wr_addr%0d", k), {96'd0, mem_addr}, {96'd0, addrs[k]});
            chk($sformatf("wr_we%0d", k), {127'd0, mem_we}, 128'd0);
        end
        next_cycle(); start = 1'b0; is_store = 1'b0; mem_ack = 1'b0; settle();
        v_load2 = 128'h000000B3_000000B2_000000B1_000000B0;
        chk("wr_done", {127'd0, done}, 128'd1);
        chk("wr_vreg_we", {127'd0, vreg_we}, 128'd1);
        chk("wr_vout", vdata_out, v_load2);
        next_cycle(); settle();
        chk("wr_no_requeue", {127'd0, mem_req}, 128'd0);
        chk("wr_idle_stall", {127'd0, stall}, 128'd0);

        // Reset during the third beat of a load.
        start = 1'b1; base_addr = 32'h300;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hC0 + k;
        end
        next_cycle(); mem_ack = 1'b0; settle();
        chk("rm_beat2_addr", {96'd0, mem_addr}, 128'h308);
        rst = 1'b0;
        next_cycle(); rst = 1'b1; settle();
        chk("rm_done", {127'd0, done}, 128'd0);
        chk("rm_vreg_we", {127'd0, vreg_we}, 128'd0);
        chk("rm_req", {127'd0, mem_req}, 128'd0);
        chk("rm_stall", {127'd0, stall}, 128'd0);
        chk("rm_vout", vdata_out, 128'd0);
        next_cycle(); settle();
        chk("rm_done_later", {127'd0, done}, 128'd0);

`ifdef VMEM_TIMEOUT_EN
        begin
            int beats;
            bit seen;
            beats = 0; seen = 1'b0;
            start = 1'b1; is_store = 1'b0; base_addr = 32'h400; mem_ack = 1'b0;
            for (int i = 0; i < 70000 && !seen; i++) begin
                next_cycle(); start = 1'b0; settle();
                if (done) seen = 1'b1;
                else if (mem_req) beats++;
            end
            chk("to_seen_done", {127'd0, seen}, 128'd1);
            chk("to_wait_cycles", 128'(beats), 128'd65535);
            chk("to_err", {127'd0, err}, 128'd1);
            chk("to_vreg_we", {127'd0, vreg_we}, 128'd0);
            next_cycle(); next_cycle(); settle();
            chk("to_err_sticky", {127'd0, err}, 128'd1);
            rst = 1'b0; next_cycle(); rst = 1'b1; settle();
            chk("to_err_cleared", {127'd0, err}, 128'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vmem_seq.md
Name: vmem_seq

Overview:
- Multi-beat sequencer for vector memory ops (vld, vst).
- Moves one LANES-wide vector through the LANE_W-wide data memory port, one lane per beat.
- Sits between the control unit's memory strobes and data memory.
- Holds a pipeline stall while the transfer is in progress.

Parameters:
LANES, 4, number of vector lanes (power of 2, >=2)
LANE_W, 32, bits per lane and memory word width
ADDR_W, 32, byte address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
start  in  1  vector mem op issued (single-cycle pulse, honoured only in IDLE)
is_store  in  1  1=vst, 0=vld; sampled with start
base_addr  in  ADDR_W  byte address of lane 0; sampled with start
vdata_in  in  LANES*LANE_W  store vector, lane i at bits [i*LANE_W +: LANE_W]; sampled with start
mem_req  out  1  memory beat request
mem_we  out  1  write enable for current beat
mem_addr  out  ADDR_W  beat byte address
mem_wdata  out  LANE_W  beat store data
mem_ack  in  1  beat accepted/complete; rdata valid same cycle
mem_rdata  in  LANE_W  load beat data
stall  out  1  freeze pipeline front
vdata_out  out  LANES*LANE_W  assembled load vector
vreg_we  out  1  one-cycle pulse: write vdata_out to the vector register file
done  out  1  one-cycle pulse at end of any op
err  out  1  timeout flag (VMEM_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE and the lane counter clears.
  - All outputs go to 0, including vdata_out and err.
  - Reset mid-transfer aborts the transfer with no done or vreg_we pulse.
- States:
  - IDLE: stall=0, mem_req=0. start=1 latches is_store, base_addr and vdata_in, clears the lane counter k, and moves to BEAT next cycle.
  - BEAT: mem_req=1, mem_addr=base+4*k (modulo 2^ADDR_W), mem_we=is_store, mem_wdata=lane k of the latched vector.
    - Outputs hold stable until mem_ack.
    - On mem_ack with a load: lane k of vdata_out <= mem_rdata.
    - On mem_ack with k<LANES-1: k increments; stay in BEAT.
    - On mem_ack with k=LANES-1: move to FIN.
  - FIN: done=1; vreg_we=1 only for loads; stall=1. Next state IDLE.
- stall=1 in BEAT and FIN, and combinationally in IDLE during the start cycle. The instruction therefore never advances before FIN completes.
- Latency with zero-wait memory (mem_ack tied high): start at cycle 0, beats at cycles 1..LANES, done at cycle LANES+1.
- start outside IDLE is ignored, with no queueing.
- mem_ack outside BEAT is ignored.
- Lanes not yet written keep their previous value in vdata_out. A completed load fully overwrites it.
- vdata_out holds until the next load completes. Stores never modify it.
- Address wrap past 2^ADDR_W-1 wraps silently.

Optional Feature:
- Macro: VMEM_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entry to each beat and increments each BEAT cycle without mem_ack.
  - At 0xFFFF: err is set (sticky until reset), FIN is entered with done=1 and vreg_we=0, then IDLE.
- Undefined:
  - No counter; err is tied to 0.
  - BEAT waits indefinitely.

Test Plan:
- Reset check: hold rst=0 two cycles, then release -> all outputs 0, IDLE, stall=0.
- Load, zero-wait: start, is_store=0, base=0x100, rdata per beat 0xA0,0xA1,0xA2,0xA3 -> addrs 0x100,0x104,0x108,0x10C on cycles 1-4; cycle 5 done=vreg_we=1; vdata_out=0x000000A3_000000A2_000000A1_000000A0.
- Store with waits: base=0x200, vdata_in lanes 0x11..0x44, ack every 3rd cycle -> mem_we=1 and address/data stable per beat; 4 beats; done=1, vreg_we=0; stall high throughout.
- Wrap and ignored start: base=0xFFFFFFF8, load -> addrs 0xFFFFFFF8,0xFFFFFFFC,0x0,0x4; a start pulse during BEAT is ignored and base is unchanged.
- Reset mid-op: rst=0 on beat 2 of a load -> no done/vreg_we; IDLE; vdata_out=0.
- VMEM_TIMEOUT_EN: mem_ack held 0 -> after 65535 wait cycles err=1, done=1, vreg_we=0; err stays 1 until reset.
